add_sequencer: RTL and testbench
================================

# add_sequencer

Multi-word addition controller that time-shares a single WIDTH-bit adder datapath (the ripple-carry `top` adder) to add two WIDTH*WORDS-bit operands, one slice per clock, least-significant slice first. It latches operands on a start handshake, drives the adder slice inputs, chains the carry through a register, assembles the result and signals completion. It sits between a requester issuing wide additions and the shared adder instance.

## Interface
- WIDTH, 4, adder slice width in bits; matches the attached adder's WIDTH
- WORDS, 4, slices per operation (>= 1); operand width N = WIDTH*WORDS
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- a_in  in  N  operand A, sampled on accepting edge
- b_in  in  N  operand B, sampled on accepting edge
- cin  in  1  carry-in to slice 0, sampled on accepting edge
- sub  in  1  subtract request (present only with ADDSEQ_SUB_EN), sampled on accepting edge
- busy  out  1  high from accept until done cycle inclusive
- done  out  1  one-cycle pulse, result valid
- sum_out  out  N  result; holds until next accept
- cout  out  1  carry out of final slice; holds with sum_out
- add_a  out  WIDTH  to adder A
- add_b  out  WIDTH  to adder B
- add_cin  out  1  to adder Cin
- add_sum  in  WIDTH  from adder Sum (combinational)
- add_cout  in  1  from adder Cout (combinational)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 at an edge -> latch a_in, b_in; carry register <= cin; idx <= 0; clear sum_out and cout; -> RUN.
- RUN: add_a = A[idx*WIDTH +: WIDTH], add_b = B[idx*WIDTH +: WIDTH], add_cin = carry register. Each edge: sum_out[idx slice] <= add_sum, carry <= add_cout, idx <= idx+1. On the edge where idx == WORDS-1: cout <= add_cout, -> DONE.
- DONE: done=1, busy=1 for exactly one cycle; next edge -> IDLE unconditionally.
- Adder drive in IDLE and DONE: add_a=0, add_b=0, add_cin=0.
- start is ignored in RUN and DONE (no queueing); a start held high through DONE is accepted on the first IDLE edge.
- Result arithmetic: {cout, sum_out} = A + B + cin, modulo 2^(N+1); no overflow flag.
- idx width = max(1, clog2(WORDS)); no wrap beyond WORDS-1.

## Timing
- Reset (any state, including mid-RUN): state=IDLE, idx=0, carry=0, busy=0, done=0, sum_out=0, cout=0; in-flight operation discarded, no done pulse.
- Accept at edge E0; busy rises after E0; slices captured at E1..E(WORDS); done high in the cycle after E(WORDS); busy and done fall after E(WORDS+1).
- Latency start-accept to done = WORDS+1 cycles; throughput one operation per WORDS+2 cycles with start held high.
- WORDS=1: single RUN cycle, done after E1.
- busy, done, sum_out, cout are registered; add_a/add_b/add_cin are decoded from registered state only.

## Configuration
- ADDSEQ_SUB_EN defined: sub port present; if sub sampled 1 at accept, B is latched as ~b_in and carry register initialised to 1 (cin ignored); result = A - B modulo 2^N, cout = 1 means no borrow. sub=0 behaves as addition.
- ADDSEQ_SUB_EN undefined: no sub port; addition only.

## Test plan
- WIDTH=4, WORDS=4: A=0x1234, B=0x0FFF, cin=0 -> sum_out=0x2233, cout=0, done exactly 5 cycles after accept, single-cycle pulse.
- A=0xFFFF, B=0x0001, cin=0 -> sum_out=0x0000, cout=1; carry propagates through all 4 slices (add_cin=1 in slices 1-3).
- A=0x0000, B=0x0000, cin=1 -> sum_out=0x0001, cout=0; A=0xFFFF, B=0xFFFF, cin=1 -> 0xFFFF, cout=1.
- start pulsed with new operands during RUN and DONE -> ignored, first result unchanged; held start re-accepted on first IDLE edge.
- rst asserted after 2 RUN cycles -> next cycle all outputs 0, state IDLE, no done; subsequent 0x0001+0x0001 -> 0x0002.
- ADDSEQ_SUB_EN: sub=1, A=0x0005, B=0x0007 -> sum_out=0xFFFE, cout=0; A=0x0007, B=0x0005 -> 0x0002, cout=1.

Source files
------------

// File: rtl/add_sequencer.sv
// Multi-word adder controller: streams WIDTH-bit slices of two N-bit operands through one shared adder, LSB slice first.
// Latency WORDS+1 cycles accept-to-done; start ignored while busy. Optional subtract build: ADDSEQ_SUB_EN.
module add_sequencer #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] a_in,
    input  logic [WIDTH*WORDS-1:0] b_in,
    input  logic                   cin,
`ifdef ADDSEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] sum_out,
    output logic                   cout,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         state_q;
    logic [WORDS-1:0][WIDTH-1:0]    a_q;
    logic [WORDS-1:0][WIDTH-1:0]    b_q;
    logic [WORDS-1:0][WIDTH-1:0]    sum_q;
    logic [IDXW-1:0]                idx_q;
    logic                           carry_q;
    logic                           cout_q;
    logic                           busy_q;
    logic                           done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
`ifdef ADDSEQ_SUB_EN
                        // Subtraction is A + ~B + 1; cout then reads as "no borrow".
                        b_q     <= sub ? ~b_in : b_in;
                        carry_q <= sub ? 1'b1 : cin;
`else
                        b_q     <= b_in;
                        carry_q <= cin;
`endif
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= add_sum;
                    carry_q      <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= add_cout;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Adder is driven only while slicing so the shared instance sees zeros otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q];
            add_b   = b_q[idx_q];
            add_cin = carry_q;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_add_sequencer.sv
// Self-checking bench for add_sequencer with a behavioural adder and reference arithmetic model.
module tb_add_sequencer;
    localparam int WIDTH = 4;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N-1:0]     a_in;
    logic [N-1:0]     b_in;
    logic             cin;
`ifdef ADDSEQ_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [N-1:0]     sum_out;
    logic             cout;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] obs_a   [WORDS];
    logic [WIDTH-1:0] obs_b   [WORDS];
    logic             obs_cin [WORDS];
    int               lat;
    logic [N-1:0]     first_sum;
    logic             first_cout;

    add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
`ifdef ADDSEQ_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum_out(sum_out), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // Shared combinational ripple adder stand-in
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always #5 clk = ~clk;

    function automatic logic [N:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic c, input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    endfunction

    // Carry entering slice i = carry out of the low i*WIDTH bits of the full sum.
    function automatic logic carry_into(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic c, input int i);
        longint unsigned mask, lo;
        mask = (64'd1 << (WIDTH * i)) - 64'd1;
        lo   = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
        return lo[WIDTH * i];
    endfunction

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
`ifdef ADDSEQ_SUB_EN
        sub = s;
`else
        if (s) $display("note: subtract requested in add-only build");
`endif
        lat = 0;
        for (int t = 1; t <= 64; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == 1) begin first_sum = sum_out; first_cout = cout; end
            if (t <= WORDS) begin
                obs_a[t-1] = add_a; obs_b[t-1] = add_b; obs_cin[t-1] = add_cin;
            end
            if (done) begin lat = t; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
`ifdef ADDSEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum_out !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=0", sum_out); end
        checks++; if (cout !== 1'b0)  begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            failures++; $display("FAIL reset_adder_drive got=%h/%h/%b exp=0/0/0", add_a, add_b, add_cin);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [N-1:0] va [4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'hFFFF};
        logic [N-1:0] vb [4] = '{16'h0FFF, 16'h0001, 16'h0000, 16'hFFFF};
        logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [N:0]   exp;
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], vc[k], 1'b0);
            exp = ref_result(va[k], vb[k], vc[k], 1'b0);
            checks++; if (lat !== WORDS + 1) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", k, lat, WORDS + 1); end
            checks++; if (sum_out !== exp[N-1:0]) begin failures++; $display("FAIL dir%0d_sum got=%h exp=%h", k, sum_out, exp[N-1:0]); end
            checks++; if (cout !== exp[N]) begin failures++; $display("FAIL dir%0d_cout got=%b exp=%b", k, cout, exp[N]); end
            checks++; if (first_sum !== '0 || first_cout !== 1'b0) begin
                failures++; $display("FAIL dir%0d_clear_on_accept got=%h/%b exp=0/0", k, first_sum, first_cout);
            end
            for (int i = 0; i < WORDS; i++) begin
                checks++;
                if (obs_a[i] !== va[k][i*WIDTH +: WIDTH] || obs_b[i] !== vb[k][i*WIDTH +: WIDTH] ||
                    obs_cin[i] !== carry_into(va[k], vb[k], vc[k], i)) begin
                    failures++;
                    $display("FAIL dir%0d_slice%0d got=%h/%h/%b exp=%h/%h/%b", k, i, obs_a[i], obs_b[i], obs_cin[i],
                             va[k][i*WIDTH +: WIDTH], vb[k][i*WIDTH +: WIDTH], carry_into(va[k], vb[k], vc[k], i));
                end
            end
            @(negedge clk);
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL dir%0d_pulse_end got done=%b busy=%b exp 0/0", k, done, busy);
            end
            checks++; if (sum_out !== exp[N-1:0]) begin failures++; $display("FAIL dir%0d_sum_hold got=%h exp=%h", k, sum_out, exp[N-1:0]); end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] a, b;
        logic         c;
        logic [N:0]   exp;
        for (int k = 0; k < 20; k++) begin
            a = N'($urandom); b = N'($urandom); c = 1'($urandom_range(0, 1));
            do_op(a, b, c, 1'b0);
            exp = ref_result(a, b, c, 1'b0);
            checks++; if (lat !== WORDS + 1 || sum_out !== exp[N-1:0] || cout !== exp[N]) begin
                failures++;
                $display("FAIL rnd%0d got lat=%0d sum=%h cout=%b exp lat=%0d sum=%h cout=%b",
                         k, lat, sum_out, cout, WORDS + 1, exp[N-1:0], exp[N]);
            end
            for (int i = 0; i < WORDS; i++) begin
                checks++;
                if (obs_cin[i] !== carry_into(a, b, c, i)) begin
                    failures++; $display("FAIL rnd%0d_carry%0d got=%b exp=%b", k, i, obs_cin[i], carry_into(a, b, c, i));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [N:0] exp1, exp2;
        int         lat2;
        exp1 = ref_result(16'h0102, 16'h0304, 1'b0, 1'b0);
        exp2 = ref_result(16'hABCD, 16'h1111, 1'b1, 1'b0);
        @(negedge clk);
        a_in = 16'h0102; b_in = 16'h0304; cin = 1'b0; start = 1'b1;
        lat = 0;
        for (int t = 1; t <= 64; t++) begin
            @(negedge clk);
            if (t == 1) begin a_in = 16'hABCD; b_in = 16'h1111; cin = 1'b1; end
            if (done) begin lat = t; break; end
        end
        checks++; if (lat !== WORDS + 1 || sum_out !== exp1[N-1:0] || cout !== exp1[N]) begin
            failures++; $display("FAIL b2b_first got lat=%0d sum=%h cout=%b exp lat=%0d sum=%h cout=%b",
                                 lat, sum_out, cout, WORDS + 1, exp1[N-1:0], exp1[N]);
        end
        lat2 = 0;
        for (int t = 1; t <= 64; t++) begin
            @(negedge clk);
            if (done) begin lat2 = t; start = 1'b0; break; end
        end
        start = 1'b0;
        checks++; if (lat2 !== WORDS + 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", lat2, WORDS + 2); end
        checks++; if (sum_out !== exp2[N-1:0] || cout !== exp2[N]) begin
            failures++; $display("FAIL b2b_second got sum=%h cout=%b exp sum=%h cout=%b", sum_out, cout, exp2[N-1:0], exp2[N]);
        end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_no_requeue got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_run;
        logic seen_done;
        @(negedge clk);
        a_in = 16'h1234; b_in = 16'h4321; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sum_out !== '0 || cout !== 1'b0) begin
            failures++; $display("FAIL midrst_outputs got busy=%b done=%b sum=%h cout=%b exp 0/0/0/0", busy, done, sum_out, cout);
        end
        checks++; if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            failures++; $display("FAIL midrst_adder got=%h/%h/%b exp=0/0/0", add_a, add_b, add_cin);
        end
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL midrst_no_done got activity=%b exp=0", seen_done); end
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        checks++; if (lat !== WORDS + 1 || sum_out !== 16'h0002 || cout !== 1'b0) begin
            failures++; $display("FAIL midrst_after got lat=%0d sum=%h cout=%b exp lat=%0d sum=0002 cout=0", lat, sum_out, cout, WORDS + 1);
        end
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub;
        logic [N-1:0] va [3] = '{16'h0005, 16'h0007, 16'hC3A5};
        logic [N-1:0] vb [3] = '{16'h0007, 16'h0005, 16'h1F2E};
        logic [N:0]   exp;
        for (int k = 0; k < 3; k++) begin
            do_op(va[k], vb[k], 1'b0, 1'b1);
            exp = ref_result(va[k], vb[k], 1'b0, 1'b1);
            checks++; if (sum_out !== exp[N-1:0] || cout !== exp[N]) begin
                failures++; $display("FAIL sub%0d got sum=%h cout=%b exp sum=%h cout=%b", k, sum_out, cout, exp[N-1:0], exp[N]);
            end
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_reset_mid_run;
`ifdef ADDSEQ_SUB_EN
        test_sub;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
